fifo_reg_ctrl: RTL

- Controller for a register-based FIFO built from DEPTH independent write-enabled register stages of DWIDTH bits each.
- Converts a valid/ready push interface into one-hot per-stage write enables.
- Tracks write/read pointers and occupancy.
- Muxes the head stage back out as a valid/ready pop interface.
- Stage registers are instantiated alongside this block, not inside it.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ptr_wrap.sv | 24 ++
 rtl/fifo_reg_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and pointer helpers for the register-stage FIFOs.
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH_DEF  = 4;
  localparam int unsigned FIFO_DWIDTH_DEF = 8;

  // Explicit compare, so wrapping works for any DEPTH, not only powers of two.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer counter with enable and synchronous clear.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int AW = $clog2(DEPTH);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= AW'(next_ptr(32'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/fifo_reg_ctrl.sv
// Push/pop controller for a FIFO whose DEPTH data stages live outside this block:
// drives one-hot stage write enables and muxes the head stage back out.
module fifo_reg_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned DWIDTH = FIFO_DWIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DEPTH-1:0]          o_wf,
  input  logic [DEPTH*DWIDTH-1:0]   i_stage_d,
  output logic [DWIDTH-1:0]         o_d,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          full_q;
  logic          empty_q;
  logic          push;
  logic          pop;

  // Handshakes only depend on registered flags, rst and flush.
  assign s_ready = !full_q && !rst && !i_flush;
  assign m_valid = !empty_q && !i_flush;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (i_flush),
    .en  (push),
    .ptr (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (i_flush),
    .en  (pop),
    .ptr (rd_ptr)
  );

  always_comb begin
    o_wf = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      o_wf[k] = push && (wr_ptr == AW'(k));
    end
  end

  always_comb begin
    o_d = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (rd_ptr == AW'(k)) begin
        o_d = i_stage_d[k*DWIDTH +: DWIDTH];
      end
    end
  end

  // full/empty are kept as flops next to the count rather than decoded from it.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          count_q <= count_q + 1'b1;
          full_q  <= (count_q == (AW+1)'(DEPTH - 1));
          empty_q <= 1'b0;
        end
        2'b01: begin
          count_q <= count_q - 1'b1;
          full_q  <= 1'b0;
          empty_q <= (count_q == (AW+1)'(1));
        end
        default: begin
          count_q <= count_q;
          full_q  <= full_q;
          empty_q <= empty_q;
        end
      endcase
    end
  end

  assign o_count = count_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;

  a_wf_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(o_wf));
  a_count_max: assert property (@(posedge clk) disable iff (rst) count_q <= (AW+1)'(DEPTH));
  a_ptr_diff:  assert property (@(posedge clk) disable iff (rst)
    ((int'(wr_ptr) - int'(rd_ptr) + int'(DEPTH)) % int'(DEPTH)) == (int'(count_q) % int'(DEPTH)));

endmodule
